if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register, directly upstream of the decode stage.
- Holds the fetch PC and fetches 32-bit instructions from instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Presents pc/instr/valid to decode and honours decode's stall.
- Takes redirects from decode's imm_pc/next_imm_pc branch/jump resolution and drops any wrong-path fetch.

Parameters:
- BUS_WIDTH, 64, PC and address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 64'h0, first fetch address after reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  from hazard unit; decode cannot accept a new instruction this cycle
- imm_pc  in  1  redirect request from decode (branch taken or jump)
- next_imm_pc  in  BUS_WIDTH  redirect target from decode
- imem_req  out  1  fetch request valid
- imem_addr  out  BUS_WIDTH  fetch address; held stable while imem_req=1 and imem_gnt=0
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid; at least 1 cycle after gnt
- imem_rdata  in  INSTR_WIDTH  fetched instruction
- pc  out  BUS_WIDTH  PC of instruction in IF/ID register
- instr  out  INSTR_WIDTH  instruction to decode
- valid  out  1  IF/ID register holds a live instruction; 0 means decode sees a bubble

Behaviour:
- Reset:
  - fetch_pc=RESET_PC; state=S_REQ; valid=0; pc=0; instr=32'h00000013 (NOP); discard=0; hold buffer empty.
  - Reset mid-transaction abandons the outstanding request. Any imem_rvalid arriving with discard=0 in S_REQ is ignored.
- Effective redirect: redir = imm_pc & valid & ~stall.
  - Target = {next_imm_pc[BUS_WIDTH-1:1], 1'b0}.
- State S_REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - gnt & ~redir: go to S_WAIT.
  - gnt & redir: go to S_WAIT with discard=1 (old address was granted).
  - ~gnt & redir: fetch_pc=target; stay in S_REQ.
- State S_WAIT:
  - imem_req=0.
  - redir sets discard=1 and fetch_pc=target.
  - On rvalid with discard=1: drop data, clear discard, go to S_REQ (fetch_pc unchanged).
  - On rvalid with discard=0 and slot free (valid=0 or stall=0), and no redir: load pc=fetch_pc, instr=imem_rdata, valid=1; fetch_pc += PC_STEP; go to S_REQ.
  - On rvalid with discard=0 and slot busy (valid=1 and stall=1): capture {fetch_pc, rdata} into hold buffer; go to S_FULL.
  - rvalid and redir in the same cycle with discard=0: the data is wrong-path; drop it, fetch_pc=target, go to S_REQ.
- State S_FULL:
  - imem_req=0.
  - When stall=0 and no redir: hold buffer moves to the output (valid=1); fetch_pc += PC_STEP; go to S_REQ.
  - On redir: drop the buffer, fetch_pc=target, valid=0, go to S_REQ.
- Output register:
  - stall=1: pc/instr/valid hold.
  - stall=0 with no new load: valid=0 (bubble); pc/instr hold.
  - redir always forces valid=0 next cycle (the branch moves on; its wrong-path successor never enters ID).
- Arithmetic: fetch_pc increment is modulo 2^BUS_WIDTH; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Latency: best case, one instruction per 2 cycles with 1-cycle memory (non-pipelined fetch, by design). Redirect penalty is the rest of the in-flight access plus one request.
- imem_addr/imem_req are direct register outputs with no combinational path from stall or imm_pc. The S_REQ address update on redirect appears the next cycle.

Decomposition:
- Shared pipeline package holds:
  - state encoding (S_REQ, S_WAIT, S_FULL; 2 bits)
  - NOP_INSTR = 32'h00000013
  - PC_STEP
  - RESET_PC default
- One natural sub-module, if_id_reg: the IF/ID register with load/hold/flush inputs. It is reusable for the hazard unit's flush later.
- The FSM, hold buffer and discard flag stay in if_stage.

Test Plan:
- Reset then 1-cycle memory, stall=0 -> imem_addr sequence 0x0,0x4,0x8; valid pulses with pc=0x0,0x4,0x8; instr matches memory; valid never high 2 consecutive cycles.
- stall=1 for 5 cycles while pc=0x4 valid and 0x8 returns -> pc/instr frozen at 0x4; 0x8 held in buffer; no imem_req in S_FULL; 1 cycle after stall drops, pc=0x8 valid.
- imm_pc=1, next_imm_pc=0x100, with fetch of 0x8 outstanding (rvalid 3 cycles later) -> valid=0 next cycle; 0x8 data dropped; next imem_addr=0x100; next valid instruction pc=0x100.
- imm_pc=1 with stall=1 -> ignored; fetch_pc unchanged; after stall clears with imm_pc=1, next_imm_pc=0x201 -> next fetch address 0x200.
- imem_gnt withheld 4 cycles -> imem_addr stable, imem_req=1 throughout; redirect arriving during the wait changes imem_addr to the target the next cycle.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 0x0; rst asserted during S_WAIT -> next cycle valid=0, imem_req=1, imem_addr=RESET_PC; late rvalid is ignored.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP and fetch defaults.
package if_stage_pkg;

    // Fetch FSM: issue request, wait for response, response parked in hold buffer
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned PC_STEP = 4;

    localparam logic [63:0] RESET_PC_DEF = 64'h0;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
// Priority: reset > flush > load > hold > bubble.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 64,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_load,
    input  logic                   i_hold,
    input  logic [BUS_WIDTH-1:0]   i_pc,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic [BUS_WIDTH-1:0]   o_pc,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_valid
);

    logic [BUS_WIDTH-1:0]   r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_valid;

    // Load a new instruction, hold under stall, otherwise drop to a bubble
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= '0;
            r_instr <= INSTR_WIDTH'(NOP_INSTR);
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end else if (!i_hold) begin
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding req/gnt/rvalid fetch, one-entry
// hold buffer for responses that arrive while decode is stalled, and redirect
// handling that discards wrong-path fetches.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned          BUS_WIDTH   = 64,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC    = BUS_WIDTH'(RESET_PC_DEF)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_stall,
    input  logic                   i_imm_pc,
    input  logic [BUS_WIDTH-1:0]   i_next_imm_pc,
    output logic                   o_imem_req,
    output logic [BUS_WIDTH-1:0]   o_imem_addr,
    input  logic                   i_imem_gnt,
    input  logic                   i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [BUS_WIDTH-1:0]   o_pc,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_valid
);

    fetch_state_e           r_state;
    logic [BUS_WIDTH-1:0]   r_fetch_pc;
    logic                   r_imem_req;
    logic                   r_discard;
    logic [BUS_WIDTH-1:0]   r_hold_pc;
    logic [INSTR_WIDTH-1:0] r_hold_instr;

    logic                   w_valid;
    logic                   w_redir;
    logic [BUS_WIDTH-1:0]   w_target;
    logic [BUS_WIDTH-1:0]   w_pc_inc;
    logic                   w_load;
    logic [BUS_WIDTH-1:0]   w_load_pc;
    logic [INSTR_WIDTH-1:0] w_load_instr;

    // A redirect only counts when decode holds a live instruction and can move on
    assign w_redir  = i_imm_pc & w_valid & ~i_stall;
    assign w_target = i_next_imm_pc & ~{{(BUS_WIDTH-1){1'b0}}, 1'b1};
    assign w_pc_inc = r_fetch_pc + BUS_WIDTH'(PC_STEP);

    // Select what enters IF/ID: fresh response or the parked hold-buffer entry
    always_comb begin
        w_load       = 1'b0;
        w_load_pc    = r_fetch_pc;
        w_load_instr = i_imem_rdata;
        case (r_state)
            S_WAIT: begin
                if (i_imem_rvalid && !r_discard && !w_redir && (!w_valid || !i_stall)) begin
                    w_load = 1'b1;
                end
            end
            S_FULL: begin
                if (!i_stall && !w_redir) begin
                    w_load       = 1'b1;
                    w_load_pc    = r_hold_pc;
                    w_load_instr = r_hold_instr;
                end
            end
            default: ;
        endcase
    end

    // Fetch FSM with fetch PC, discard flag, hold buffer and registered imem_req
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_imem_req   <= 1'b1;
            r_discard    <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_imem_gnt) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                        if (w_redir) begin
                            // Old address already granted; its response must be dropped
                            r_discard  <= 1'b1;
                            r_fetch_pc <= w_target;
                        end
                    end else if (w_redir) begin
                        r_fetch_pc <= w_target;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (r_discard) begin
                            r_discard  <= 1'b0;
                            r_state    <= S_REQ;
                            r_imem_req <= 1'b1;
                            if (w_redir) begin
                                r_fetch_pc <= w_target;
                            end
                        end else if (w_redir) begin
                            r_fetch_pc <= w_target;
                            r_state    <= S_REQ;
                            r_imem_req <= 1'b1;
                        end else if (!w_valid || !i_stall) begin
                            r_fetch_pc <= w_pc_inc;
                            r_state    <= S_REQ;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_hold_pc    <= r_fetch_pc;
                            r_hold_instr <= i_imem_rdata;
                            r_state      <= S_FULL;
                        end
                    end else if (w_redir) begin
                        r_discard  <= 1'b1;
                        r_fetch_pc <= w_target;
                    end
                end
                S_FULL: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_target;
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end else if (!i_stall) begin
                        r_fetch_pc <= w_pc_inc;
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .BUS_WIDTH   (BUS_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_redir),
        .i_load  (w_load),
        .i_hold  (i_stall),
        .i_pc    (w_load_pc),
        .i_instr (w_load_instr),
        .o_pc    (o_pc),
        .o_instr (o_instr),
        .o_valid (w_valid)
    );

    assign o_valid     = w_valid;
    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_fetch_pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall with hold buffer,
// redirects, grant back-pressure, PC wrap and mid-transaction reset.
module tb_if_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        rst, stall, imm_pc, gnt, rvalid;
    logic [63:0] next_imm_pc;
    logic [31:0] rdata;
    logic        req, valid;
    logic [63:0] addr, pc;
    logic [31:0] instr;

    // Wrap DUT (RESET_PC near top of address space)
    logic        x_rst, x_stall, x_imm_pc, x_gnt, x_rvalid;
    logic [63:0] x_next_imm_pc;
    logic [31:0] x_rdata;
    logic        x_req, x_valid;
    logic [63:0] x_addr, x_pc;
    logic [31:0] x_instr;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] NOP     = 64'h0000_0000_0000_0013;

    if_stage u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_imm_pc      (imm_pc),
        .i_next_imm_pc (next_imm_pc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_pc          (pc),
        .o_instr       (instr),
        .o_valid       (valid)
    );

    if_stage #(
        .RESET_PC (WRAP_PC)
    ) u_dut_wrap (
        .i_clk         (clk),
        .i_rst         (x_rst),
        .i_stall       (x_stall),
        .i_imm_pc      (x_imm_pc),
        .i_next_imm_pc (x_next_imm_pc),
        .o_imem_req    (x_req),
        .o_imem_addr   (x_addr),
        .i_imem_gnt    (x_gnt),
        .i_imem_rvalid (x_rvalid),
        .i_imem_rdata  (x_rdata),
        .o_pc          (x_pc),
        .o_instr       (x_instr),
        .o_valid       (x_valid)
    );

    // Memory contents: each word derived from its address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h0BAD_C0DE;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; imm_pc = 1'b0; next_imm_pc = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        x_rst = 1'b1; x_stall = 1'b0; x_imm_pc = 1'b0; x_next_imm_pc = '0;
        x_gnt = 1'b0; x_rvalid = 1'b0; x_rdata = '0;
        tick();
        tick();
        rst = 1'b0; x_rst = 1'b0;

        // Reset state
        check("rst_req",   64'(req),   64'd1);
        check("rst_addr",  addr,       64'h0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_pc",    pc,         64'h0);
        check("rst_instr", 64'(instr), NOP);

        // Sequential fetch with 1-cycle memory
        gnt = 1'b1; tick();
        check("f0_req_wait", 64'(req),   64'd0);
        check("f0_valid_w",  64'(valid), 64'd0);
        gnt = 1'b0; rvalid = 1'b1; rdata = mem_word(64'h0); tick();
        check("f0_valid", 64'(valid), 64'd1);
        check("f0_pc",    pc,         64'h0);
        check("f0_instr", 64'(instr), 64'(mem_word(64'h0)));
        check("f1_req",   64'(req),   64'd1);
        check("f1_addr",  addr,       64'h4);
        rvalid = 1'b0; gnt = 1'b1; tick();
        check("f1_bubble", 64'(valid), 64'd0);
        gnt = 1'b0; rvalid = 1'b1; rdata = mem_word(64'h4); tick();
        check("f1_valid", 64'(valid), 64'd1);
        check("f1_pc",    pc,         64'h4);
        check("f1_instr", 64'(instr), 64'(mem_word(64'h4)));
        check("f2_addr",  addr,       64'h8);
        rvalid = 1'b0;

        // Stall 5 cycles: 0x8 returns into the hold buffer, pc=0x4 frozen
        stall = 1'b1; gnt = 1'b1; tick();
        check("st_pc_a",    pc,         64'h4);
        check("st_valid_a", 64'(valid), 64'd1);
        gnt = 1'b0; rvalid = 1'b1; rdata = mem_word(64'h8); tick();
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("st_pc",    pc,         64'h4);
            check("st_instr", 64'(instr), 64'(mem_word(64'h4)));
            check("st_noreq", 64'(req),   64'd0);
            tick();
        end
        check("st_pc_last",    pc,       64'h4);
        check("st_noreq_last", 64'(req), 64'd0);
        stall = 1'b0; tick();
        check("drain_valid", 64'(valid), 64'd1);
        check("drain_pc",    pc,         64'h8);
        check("drain_instr", 64'(instr), 64'(mem_word(64'h8)));
        check("drain_req",   64'(req),   64'd1);
        check("drain_addr",  addr,       64'hC);

        // Redirect to 0x100 while the fetch of 0xC is outstanding
        stall = 1'b1; gnt = 1'b1; tick();
        check("rd_hold_valid", 64'(valid), 64'd1);
        stall = 1'b0; gnt = 1'b0; imm_pc = 1'b1; next_imm_pc = 64'h100; tick();
        check("rd_flush", 64'(valid), 64'd0);
        check("rd_noreq", 64'(req),   64'd0);
        imm_pc = 1'b0; tick();
        check("rd_wait_noreq", 64'(req), 64'd0);
        rvalid = 1'b1; rdata = mem_word(64'hC); tick();
        check("rd_drop_valid", 64'(valid), 64'd0);
        check("rd_req",        64'(req),   64'd1);
        check("rd_addr",       addr,       64'h100);
        rvalid = 1'b0; gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = mem_word(64'h100); tick();
        check("rd_tgt_valid", 64'(valid), 64'd1);
        check("rd_tgt_pc",    pc,         64'h100);
        check("rd_tgt_instr", 64'(instr), 64'(mem_word(64'h100)));
        rvalid = 1'b0;

        // Redirect under stall is ignored; afterwards odd target is aligned
        stall = 1'b1; imm_pc = 1'b1; next_imm_pc = 64'h300; tick();
        check("ign_addr",  addr,       64'h104);
        check("ign_valid", 64'(valid), 64'd1);
        check("ign_pc",    pc,         64'h100);
        stall = 1'b0; next_imm_pc = 64'h201; tick();
        check("al_addr",  addr,       64'h200);
        check("al_req",   64'(req),   64'd1);
        check("al_valid", 64'(valid), 64'd0);
        imm_pc = 1'b0;

        // Grant withheld 4 cycles: request and address held
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gw_req",  64'(req), 64'd1);
            check("gw_addr", addr,     64'h200);
        end
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = mem_word(64'h200); tick();
        check("gw_pc", pc, 64'h200);
        rvalid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("gw2_addr", addr,     64'h204);
            check("gw2_req",  64'(req), 64'd1);
        end
        stall = 1'b0; imm_pc = 1'b1; next_imm_pc = 64'h400; tick();
        check("gw_redir_addr",  addr,       64'h400);
        check("gw_redir_valid", 64'(valid), 64'd0);
        imm_pc = 1'b0; gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = mem_word(64'h400); tick();
        check("gw_tgt_pc",    pc,         64'h400);
        check("gw_tgt_valid", 64'(valid), 64'd1);
        rvalid = 1'b0;

        // Grant and redirect in the same cycle: granted response discarded
        gnt = 1'b1; imm_pc = 1'b1; next_imm_pc = 64'h500; tick();
        check("gr_valid", 64'(valid), 64'd0);
        gnt = 1'b0; imm_pc = 1'b0; rvalid = 1'b1; rdata = mem_word(64'h404); tick();
        check("gr_drop_valid", 64'(valid), 64'd0);
        check("gr_addr",       addr,       64'h500);
        rvalid = 1'b0;

        // Wrap DUT: PC wraps to 0; reset during S_WAIT ignores late rvalid
        check("w_addr0", x_addr,      WRAP_PC);
        check("w_req0",  64'(x_req),  64'd1);
        x_gnt = 1'b1; tick();
        x_gnt = 1'b0; x_rvalid = 1'b1; x_rdata = mem_word(WRAP_PC); tick();
        check("w_pc",    x_pc,          WRAP_PC);
        check("w_valid", 64'(x_valid),  64'd1);
        check("w_addr1", x_addr,        64'h0);
        x_rvalid = 1'b0; x_gnt = 1'b1; tick();
        check("w_wait_noreq", 64'(x_req), 64'd0);
        x_gnt = 1'b0; x_rst = 1'b1; tick();
        check("wr_valid", 64'(x_valid), 64'd0);
        check("wr_req",   64'(x_req),   64'd1);
        check("wr_addr",  x_addr,       WRAP_PC);
        check("wr_instr", 64'(x_instr), NOP);
        x_rst = 1'b0; x_rvalid = 1'b1; x_rdata = 32'hDEAD_BEEF; tick();
        check("late_valid", 64'(x_valid), 64'd0);
        check("late_req",   64'(x_req),   64'd1);
        check("late_addr",  x_addr,       WRAP_PC);
        x_rvalid = 1'b0; tick();
        check("late_valid2", 64'(x_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
